// File: rtl/guess_controller.sv
// rtl/guess_controller.sv - button debounce, LFSR secret and guessing-game FSM
// Feeds SystemValAtGuess and GuessNum to the seven-segment display driver.
module guess_controller #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter int          MAX_GUESSES     = 15,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       btn_new,
  input  logic       btn_guess,
  input  logic [3:0] sw,
  output logic [3:0] SystemValAtGuess,
  output logic [3:0] GuessNum,
  output logic       led_high,
  output logic       led_low,
  output logic       led_win,
  output logic       led_lose,
  output logic [3:0] secret_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  // Bit 0 is the new-game button, bit 1 the guess button.
  logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
  logic [CW-1:0] cnt_q [2];
  logic          new_p, guess_p;

  logic [15:0]   lfsr_q, lfsr_d;

  state_t        state_q;
  logic [3:0]    secret_q, val_q, gn_q, gn_inc;
  logic          high_q, low_q, win_q, lose_q;

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {btn_guess, btn_new};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      // Count only while the synchronized level disagrees; any agreement restarts it.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign new_p   = press_q[0];
  assign guess_p = press_q[1];

  // Fibonacci taps 16, 14, 13, 11 shifting toward the MSB.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clock_100Mhz) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign gn_inc = gn_q + 4'd1;

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q  <= IDLE;
      secret_q <= '0;
      val_q    <= '0;
      gn_q     <= '0;
      high_q   <= 1'b0;
      low_q    <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else if (new_p) begin
      state_q  <= PLAY;
      secret_q <= lfsr_q[3:0];
      val_q    <= '0;
      gn_q     <= '0;
      high_q   <= 1'b0;
      low_q    <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else if (guess_p && state_q == PLAY) begin
      val_q <= sw;
      gn_q  <= gn_inc;
      if (sw == secret_q) begin
        state_q <= WIN;
        win_q   <= 1'b1;
        high_q  <= 1'b0;
        low_q   <= 1'b0;
      end else begin
        high_q <= sw > secret_q;
        low_q  <= sw < secret_q;
        if (gn_inc == 4'(MAX_GUESSES)) begin
          state_q <= LOSE;
          lose_q  <= 1'b1;
        end
      end
    end
  end

  assign SystemValAtGuess = val_q;
  assign GuessNum         = gn_q;
  assign led_high         = high_q;
  assign led_low          = low_q;
  assign led_win          = win_q;
  assign led_lose         = lose_q;
  assign secret_dbg       = secret_q;

endmodule
